mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have parameter ITER, default WIDTH, giving the number of shift-add iterations.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port Start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-006 SHALL have port Accumulate  input  1  1 = MLA (add AccIn), 0 = MUL; sampled with Start.
REQ-007 SHALL have port SrcA  input  WIDTH  multiplicand; sampled with Start.
REQ-008 SHALL have port SrcB  input  WIDTH  multiplier; sampled with Start.
REQ-009 SHALL have port AccIn  input  WIDTH  accumulate operand; sampled with Start.
REQ-010 SHALL have port Result  output  WIDTH  low WIDTH bits of SrcA*SrcB (+AccIn).
REQ-011 SHALL have port ALUFlags  output  4  {N,Z,C,V} in the processor flag order; C,V driven 0.
REQ-012 SHALL have port FlagW  output  2  flag write mask for the status register; 2'b10 (N,Z only) during Done, else 2'b00.
REQ-013 SHALL have port Busy  output  1  high while iterating; processor stalls on it.
REQ-014 SHALL have port Done  output  1  one-cycle pulse, Result/ALUFlags valid.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: Start=1 SHALL capture operands, load accumulator with AccIn if Accumulate else 0, clear iteration counter, go to RUN.
REQ-017 RUN: each cycle SHALL add the shifted multiplicand to the accumulator if the multiplier LSB is 1, shift the multiplicand left 1 and the multiplier right 1, and increment the counter.
REQ-018 All arithmetic SHALL be modulo 2^WIDTH; carry-out discarded.
REQ-019 RUN SHALL last exactly ITER cycles (no early termination), then go to DONE.
REQ-020 Start sampled at edge E0 SHALL give Busy=1 for cycles after E0..E(ITER), and Done=1 for exactly one cycle after E(ITER).
REQ-021 DONE: Result SHALL equal the accumulator; N = Result[WIDTH-1], Z = (Result==0).
REQ-022 DONE with Start=0 SHALL return to IDLE; DONE with Start=1 SHALL start a new operation as in REQ-016 (back-to-back).
REQ-023 Start during RUN SHALL be ignored; captured operands SHALL be unaffected by input changes during RUN.
REQ-024 Result and ALUFlags[3:2] SHALL hold their last values through IDLE and RUN until the next DONE.
REQ-025 Busy SHALL be 1 exactly in RUN; Done exactly in DONE; FlagW nonzero only in DONE.

Reset
REQ-026 reset SHALL force IDLE, Result=0, ALUFlags=0, Busy=0, Done=0, FlagW=0, counter=0, with priority over Start.
REQ-027 reset asserted mid-RUN SHALL abort the operation; no Done pulse SHALL follow for the aborted operation.

Structure
REQ-028 State enum and default ITER constant SHALL reside in shared package mul_pkg.
REQ-029 Result/flag holding register SHALL be instantiated from the existing enable-reset flop (flopenr); no other sub-module.

Verification
REQ-030 SrcA=3, SrcB=5, Accumulate=0 -> Done 33 cycles after Start, Result=15, ALUFlags=4'b0000, FlagW=2'b10.
REQ-031 SrcA=0x1234, SrcB=0 -> Result=0, ALUFlags=4'b0100.
REQ-032 SrcA=0xFFFFFFFF, SrcB=2 -> Result=0xFFFFFFFE, ALUFlags=4'b1000.
REQ-033 Accumulate=1, SrcA=7, SrcB=6, AccIn=100 -> Result=142; then Start held in DONE with 2*2 -> Result=4 exactly 33 cycles later, Busy low only in the DONE cycle.
REQ-034 Start pulse again at cycle 5 of RUN with different operands -> ignored, original Result delivered on schedule.
REQ-035 reset at RUN cycle 10 -> next cycle Busy=0, Done=0, Result=0; no Done over the following 40 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_pkg;

    // Default operand/result width and the matching default iteration count.
    localparam int MUL_WIDTH_DEFAULT = 32;
    localparam int MUL_ITER_DEFAULT  = MUL_WIDTH_DEFAULT;

    // Flag write mask presented while a result is valid: N and Z only.
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_NONE = 2'b00;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/flopenr.sv
// Enable flop with synchronous active-high reset.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset, otherwise load d when enabled and hold when not.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier / multiply-accumulate with N,Z flags.
// One operand bit is consumed per RUN cycle; Result and flags are latched
// into a holding register on the last iteration and stay there until the
// next completed operation.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Accumulate,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] AccIn,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic [1:0]       FlagW,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    mul_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       flagw_q;

    logic [WIDTH-1:0] acc_d;
    logic             last_s;
    logic             hold_en_s;
    logic [WIDTH+1:0] hold_d;
    logic [WIDTH+1:0] hold_q;

    // Next accumulator value for this iteration, plus the result/flag load on the final step.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
        last_s    = (cnt_q == LAST_CNT);
        hold_en_s = (state_q == RUN) && last_s;
        hold_d    = {acc_d[WIDTH-1], (acc_d == {WIDTH{1'b0}}), acc_d};
    end

    // Holding register for {N, Z, Result}; loads only as the operation completes.
    flopenr #(
        .WIDTH(WIDTH + 2)
    ) u_hold (
        .clk  (clk),
        .reset(reset),
        .en   (hold_en_s),
        .d    (hold_d),
        .q    (hold_q)
    );

    // Controller: operand capture, shift-add datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flagw_q  <= FLAGW_NONE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        mcand_q  <= SrcA;
                        mplier_q <= SrcB;
                        acc_q    <= Accumulate ? AccIn : {WIDTH{1'b0}};
                        cnt_q    <= {CW{1'b0}};
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                    done_q  <= 1'b0;
                    flagw_q <= FLAGW_NONE;
                end
                RUN: begin
                    // Start is deliberately ignored here; operands live only in the _q copies.
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_s) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        flagw_q <= FLAGW_NZ;
                    end else begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        flagw_q <= FLAGW_NONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    flagw_q <= FLAGW_NONE;
                end
            endcase
        end
    end

    assign Result   = hold_q[WIDTH-1:0];
    assign ALUFlags = {hold_q[WIDTH+1], hold_q[WIDTH], 2'b00};
    assign FlagW    = flagw_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
